// File: rtl/adc_pkg.sv
// Shared SAR ADC constants: resolution, data width seen by the oversampling stage, FSM encoding.
// Pure declarations; no timing or flow control.
package adc_pkg;

   localparam int RESOLUTION   = 12;
   localparam int SAMPLE_CNT_W = 4;
   localparam int DATA_W       = RESOLUTION;
   localparam int BIT_IDX_W    = $clog2(RESOLUTION);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SAMPLE  = 2'd1;
   localparam logic [1:0] ST_CONVERT = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   typedef logic [DATA_W-1:0] adc_code_t;

   function automatic adc_code_t bit_mask(input logic [BIT_IDX_W-1:0] idx);
      bit_mask = adc_code_t'(1) << idx;
   endfunction

endpackage

// File: rtl/adc_sar_register.sv
// SAR trial register and bit pointer: load sets the MSB trial, each step keeps/clears the current bit.
// One decision per step clock; o_result is the code including the decision on the current edge.
module adc_sar_register
   import adc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_step,
   input  logic              i_comp,
   output logic [DATA_W-1:0] o_code,
   output logic [DATA_W-1:0] o_result,
   output logic              o_last
);

   logic [DATA_W-1:0]    r_code;
   logic [BIT_IDX_W-1:0] r_bit;
   logic [DATA_W-1:0]    w_decided;
   logic [DATA_W-1:0]    w_next;
   logic                 w_last;

   assign w_last = (r_bit == '0);

   always_comb begin
      w_decided = r_code;
      if (!i_comp) begin
         w_decided = r_code & ~bit_mask(r_bit);
      end
      w_next = w_decided;
      if (!w_last) begin
         w_next = w_decided | bit_mask(r_bit - BIT_IDX_W'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_code <= '0;
         r_bit  <= BIT_IDX_W'(RESOLUTION - 1);
      end else if (i_load) begin
         r_code <= bit_mask(BIT_IDX_W'(RESOLUTION - 1));
         r_bit  <= BIT_IDX_W'(RESOLUTION - 1);
      end else if (i_step) begin
         r_code <= w_next;
         if (!w_last) begin
            r_bit <= r_bit - BIT_IDX_W'(1);
         end
      end
   end

   assign o_code   = r_code;
   assign o_result = w_decided;
   assign o_last   = w_last;

endmodule

// File: rtl/adc_sar_control.sv
// SAR ADC sequencer: IDLE -> SAMPLE (S+1 clk) -> CONVERT (12 clk) -> DONE (1 clk, strobe).
// Result every S+14 clocks; no backpressure, start is ignored while busy.
module adc_sar_control
   import adc_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_conversion_in,
   input  logic                    continuous_in,
   input  logic [SAMPLE_CNT_W-1:0] sample_cycles_in,
   input  logic                    comparator_in,
   output logic                    sample_out,
   output logic [RESOLUTION-1:0]   dac_code_out,
   output logic [RESOLUTION-1:0]   data_out,
   output logic                    data_valid_strobe_out,
   output logic                    busy_out
);

   logic [1:0]              r_state;
   logic [SAMPLE_CNT_W-1:0] r_scnt;
   logic [DATA_W-1:0]       r_data;
   logic                    r_strobe;
   logic                    w_load;
   logic                    w_step;
   logic [DATA_W-1:0]       w_code;
   logic [DATA_W-1:0]       w_result;
   logic                    w_last;

   assign w_load = (r_state == ST_SAMPLE) && (r_scnt == '0);
   assign w_step = (r_state == ST_CONVERT);

   adc_sar_register u_sar (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_step   (w_step),
      .i_comp   (comparator_in),
      .o_code   (w_code),
      .o_result (w_result),
      .o_last   (w_last)
   );

   // data_out and the strobe change on the same edge so the downstream stage,
   // clocked by the strobe, sees stable data across the whole pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_scnt   <= '0;
         r_data   <= '0;
         r_strobe <= 1'b0;
      end else begin
         r_strobe <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_conversion_in) begin
                  r_scnt  <= sample_cycles_in;
                  r_state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (r_scnt == '0) begin
                  r_state <= ST_CONVERT;
               end else begin
                  r_scnt <= r_scnt - SAMPLE_CNT_W'(1);
               end
            end
            ST_CONVERT: begin
               if (w_last) begin
                  r_data   <= w_result;
                  r_strobe <= 1'b1;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (continuous_in) begin
                  r_scnt  <= sample_cycles_in;
                  r_state <= ST_SAMPLE;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign sample_out            = (r_state == ST_SAMPLE);
   assign busy_out              = (r_state != ST_IDLE);
   assign dac_code_out          = ((r_state == ST_CONVERT) || (r_state == ST_DONE)) ? w_code : '0;
   assign data_out              = r_data;
   assign data_valid_strobe_out = r_strobe;

endmodule

// File: tb/tb_adc_sar_control.sv
// Directed bench for adc_sar_control with an ideal comparator (Vin >= DAC code).
// Latency is measured as edges from the start-sampling edge to the edge closing the strobe cycle.
module tb_adc_sar_control;

   logic        clk;
   logic        rst_n;
   logic        start_conversion_in;
   logic        continuous_in;
   logic [3:0]  sample_cycles_in;
   logic        comparator_in;
   logic        sample_out;
   logic [11:0] dac_code_out;
   logic [11:0] data_out;
   logic        data_valid_strobe_out;
   logic        busy_out;

   logic [11:0] vin;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_strobes = 0;
   int          n_sample_hi = 0;
   logic        prev_samp = 1'b0;
   logic [11:0] first_trial = 12'h000;

   adc_sar_control dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .start_conversion_in   (start_conversion_in),
      .continuous_in         (continuous_in),
      .sample_cycles_in      (sample_cycles_in),
      .comparator_in         (comparator_in),
      .sample_out            (sample_out),
      .dac_code_out          (dac_code_out),
      .data_out              (data_out),
      .data_valid_strobe_out (data_valid_strobe_out),
      .busy_out              (busy_out)
   );

   assign comparator_in = (vin >= dac_code_out);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (data_valid_strobe_out) n_strobes <= n_strobes + 1;
      if (sample_out) n_sample_hi <= n_sample_hi + 1;
      if (prev_samp && !sample_out && busy_out) first_trial <= dac_code_out;
      prev_samp <= sample_out;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_conv(input logic [11:0] v, input logic [3:0] s, output int t0);
      vin                 = v;
      sample_cycles_in    = s;
      start_conversion_in = 1'b1;
      tick();
      t0                  = cyc;
      start_conversion_in = 1'b0;
   endtask

   task automatic wait_strobe(input int budget, output int at, output logic ok);
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (data_valid_strobe_out) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int   t0;
      int   at;
      int   prev;
      int   sb;
      int   sh;
      logic ok;

      rst_n               = 1'b0;
      start_conversion_in = 1'b0;
      continuous_in       = 1'b0;
      sample_cycles_in    = 4'd0;
      vin                 = 12'h000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sample", sample_out, 0);
      check("rst_dac", dac_code_out, 0);
      check("rst_data", data_out, 0);
      check("rst_strobe", data_valid_strobe_out, 0);
      check("rst_busy", busy_out, 0);
      rst_n = 1'b1;
      tick();

      // 1) single conversion, S=0
      sb = n_strobes;
      start_conv(12'h123, 4'd0, t0);
      wait_strobe(60, at, ok);
      check("t1_seen", ok, 1);
      check("t1_latency", at - t0 + 1, 14);
      check("t1_data", data_out, 12'h123);
      check("t1_trial", first_trial, 12'h800);
      tick();
      check("t1_busy_after", busy_out, 0);
      repeat (5) tick();
      check("t1_one_strobe", n_strobes - sb, 1);

      // 2) full-scale then zero
      start_conv(12'hFFF, 4'd0, t0);
      wait_strobe(60, at, ok);
      check("t2_seen_fff", ok, 1);
      check("t2_data_fff", data_out, 12'hFFF);
      check("t2_dac_done", dac_code_out, 12'hFFF);
      check("t2_trial_fff", first_trial, 12'h800);
      repeat (2) tick();
      start_conv(12'h000, 4'd0, t0);
      wait_strobe(60, at, ok);
      check("t2_seen_000", ok, 1);
      check("t2_data_000", data_out, 12'h000);
      check("t2_trial_000", first_trial, 12'h800);
      repeat (2) tick();

      // 3) continuous, S=3: one result every 17 clocks
      continuous_in = 1'b1;
      start_conv(12'h890, 4'd3, t0);
      wait_strobe(60, at, ok);
      check("t3_seen", ok, 1);
      check("t3_latency", at - t0 + 1, 17);
      check("t3_data0", data_out, 12'h890);
      prev = at;
      for (int k = 0; k < 3; k++) begin
         wait_strobe(60, at, ok);
         check("t3_period", at - prev, 17);
         check("t3_data", data_out, 12'h890);
         prev = at;
      end
      continuous_in = 1'b0;
      tick();
      check("t3_idle", busy_out, 0);
      repeat (2) tick();

      // 4) start re-pulsed and sample length changed mid-conversion
      sb = n_strobes;
      start_conv(12'h5A5, 4'd2, t0);
      repeat (6) tick();
      check("t4_in_convert", {sample_out, busy_out}, 2'b01);
      start_conversion_in = 1'b1;
      sample_cycles_in    = 4'd9;
      tick();
      start_conversion_in = 1'b0;
      wait_strobe(60, at, ok);
      check("t4_seen", ok, 1);
      check("t4_latency", at - t0 + 1, 16);
      check("t4_data", data_out, 12'h5A5);
      repeat (40) tick();
      check("t4_no_extra", n_strobes - sb, 1);
      check("t4_idle", busy_out, 0);

      // 5) reset asserted in CONVERT cycle 6
      start_conv(12'hABC, 4'd1, t0);
      repeat (7) tick();
      check("t5_busy_pre", busy_out, 1);
      sb    = n_strobes;
      rst_n = 1'b0;
      #1;
      check("t5_rst_sample", sample_out, 0);
      check("t5_rst_dac", dac_code_out, 0);
      check("t5_rst_data", data_out, 0);
      check("t5_rst_busy", busy_out, 0);
      repeat (20) tick();
      check("t5_no_strobe", n_strobes - sb, 0);
      rst_n = 1'b1;
      tick();
      start_conv(12'hABC, 4'd1, t0);
      wait_strobe(60, at, ok);
      check("t5_seen", ok, 1);
      check("t5_latency", at - t0 + 1, 15);
      check("t5_data", data_out, 12'hABC);
      repeat (2) tick();

      // 6) S=15 sample window; continuous cleared during SAMPLE
      sh            = n_sample_hi;
      sb            = n_strobes;
      continuous_in = 1'b1;
      start_conv(12'h3C7, 4'd15, t0);
      repeat (5) tick();
      check("t6_sampling", sample_out, 1);
      continuous_in = 1'b0;
      wait_strobe(80, at, ok);
      check("t6_seen", ok, 1);
      check("t6_latency", at - t0 + 1, 29);
      check("t6_data", data_out, 12'h3C7);
      tick();
      check("t6_idle", busy_out, 0);
      repeat (40) tick();
      check("t6_sample_len", n_sample_hi - sh, 16);
      check("t6_one_strobe", n_strobes - sb, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
